// File: rtl/mlp_weight_pkg.sv
// -----------------------------------------------------------------------------
// mlp_weight_pkg
// Shared definitions for the MLP weight register files and their write-side
// loader: weight word width, regfile address width, words per load, the loader
// FSM state encoding and the weight word type.
// -----------------------------------------------------------------------------
package mlp_weight_pkg;

    localparam int WEIGHT_W      = 16;
    localparam int WEIGHT_ADDR_W = 14;
    localparam int WEIGHT_DEPTH  = 15;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_LOAD,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

    typedef logic [WEIGHT_W-1:0] weight_t;

endpackage : mlp_weight_pkg

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
// Takes a valid/ready stream of fixed-point weights and writes DEPTH words,
// in order from address 0, into a weight register file through one write port.
// Terminates in DONE on a correctly framed stream, or ERROR on a short or long
// stream (and, with the checksum option, on a bad or unframed checksum).
//
// Optional build macro:
//   WEIGHT_CHECKSUM_EN - the stream carries DEPTH data beats plus a trailing
//                        checksum beat (modulo-2**DATA_W sum of the data
//                        words). The checksum beat is never written; in_last
//                        must sit on it.
//
// Ports:
//   clk           in   single clock, all state on posedge
//   rst_n         in   synchronous active-low reset
//   start         in   begin a load (honoured in IDLE/DONE/ERROR only)
//   in_valid      in   stream word present
//   in_ready      out  loader accepts a word this cycle (high in LOAD)
//   in_data       in   stream word
//   in_last       in   final beat of the stream
//   wr_en         out  regfile write strobe (one cycle after acceptance)
//   wr_addr       out  regfile write address
//   wr_data       out  regfile write data
//   busy          out  high in LOAD
//   done          out  clean completion, sticky until next start
//   err           out  framing/checksum error, sticky until next start
//   words_loaded  out  words written in the current/last load
// -----------------------------------------------------------------------------
module weight_loader
    import mlp_weight_pkg::*;
#(
    parameter int DATA_W = WEIGHT_W,
    parameter int ADDR_W = WEIGHT_ADDR_W,
    parameter int DEPTH  = WEIGHT_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    // Beat index of the final data word. The index is one bit wider than the
    // address so that, with the checksum option, it can reach DEPTH to mark
    // the checksum beat.
    localparam logic [ADDR_W:0] LP_LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] LP_ONE      = (ADDR_W + 1)'(1);

    loader_state_t     r_state;
    logic [ADDR_W:0]   r_idx;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_words;
`ifdef WEIGHT_CHECKSUM_EN
    localparam logic [ADDR_W:0] LP_CKS_IDX = (ADDR_W + 1)'(DEPTH);
    logic [DATA_W-1:0] r_sum;
`endif

    logic w_in_ready;
    logic w_accept;

    // Ready is a pure function of state, so a start cycle (state still IDLE)
    // never accepts a beat even if in_valid is high.
    assign w_in_ready = (r_state == LD_LOAD);
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: every register here is control/output state, so all of it
            // is reset; the regfile being written lives outside this block.
            r_state   <= LD_IDLE;
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_words   <= '0;
`ifdef WEIGHT_CHECKSUM_EN
            r_sum     <= '0;
`endif
        end else begin
            // NOTE: the strobe defaults low every cycle and is raised only by
            // an accepted data beat, giving a single-cycle registered pulse.
            r_wr_en <= 1'b0;

            case (r_state)
                LD_IDLE, LD_DONE, LD_ERROR: begin
                    if (start) begin
                        r_state <= LD_LOAD;
                        r_idx   <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_words <= '0;
`ifdef WEIGHT_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end

                LD_LOAD: begin
                    if (w_accept) begin
`ifdef WEIGHT_CHECKSUM_EN
                        if (r_idx == LP_CKS_IDX) begin
                            // Checksum beat: compared, never written.
                            if (in_last && (in_data == r_sum)) begin
                                r_state <= LD_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= LD_ERROR;
                                r_err   <= 1'b1;
                            end
                        end else begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_idx[ADDR_W-1:0];
                            r_wr_data <= in_data;
                            r_words   <= r_words + LP_ONE;
                            r_sum     <= r_sum + in_data;
                            r_idx     <= r_idx + LP_ONE;
                            // Last on any data beat is a short frame; the
                            // word itself is still written.
                            if (in_last) begin
                                r_state <= LD_ERROR;
                                r_err   <= 1'b1;
                            end
                        end
`else
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_idx[ADDR_W-1:0];
                        r_wr_data <= in_data;
                        r_words   <= r_words + LP_ONE;
                        if (r_idx == LP_LAST_IDX) begin
                            // Final slot: last marks a clean load, its
                            // absence a stream that runs long.
                            if (in_last) begin
                                r_state <= LD_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= LD_ERROR;
                                r_err   <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + LP_ONE;
                            if (in_last) begin
                                r_state <= LD_ERROR;
                                r_err   <= 1'b1;
                            end
                        end
`endif
                    end
                end

                default: r_state <= LD_IDLE;
            endcase
        end
    end

    assign in_ready     = w_in_ready;
    assign busy         = w_in_ready;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule : weight_loader

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
// Directed bench for weight_loader. A monitor logs every regfile write; each
// scenario compares the log and the status outputs against hand-derived
// values. Inputs are driven and outputs sampled on the falling clock edge.
// Build with WEIGHT_CHECKSUM_EN defined to exercise the checksum framing.
// -----------------------------------------------------------------------------
module tb_weight_loader;
    import mlp_weight_pkg::*;

    localparam int DW = WEIGHT_W;
    localparam int AW = WEIGHT_ADDR_W;
    localparam int DP = WEIGHT_DEPTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int n_vec = 0;
    int n_bad = 0;
    int busy_low = 0;
    int ready_low = 0;

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];

    weight_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Outputs only change on posedge, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected writes: n words, address i holding data i+1.
    task automatic check_writes(input string tag, input int n);
        check({tag, "_count"}, log_addr.size(), n);
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(log_addr[i]), i);
            check($sformatf("%s_data%0d", tag, i), 32'(log_data[i]), i + 1);
        end
    endtask

    // Called on a falling edge with no write strobe in flight.
    task automatic start_load();
        log_addr.delete();
        log_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Beats i = 0..n-1 carry data i+1; in_last set on beat last_at.
    task automatic send_beats(input int n, input int last_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int g = 0; g < idle; g++) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    if (busy !== 1'b1) busy_low++;
                end
            end
            if (in_ready !== 1'b1) ready_low++;
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            in_last  = (i == last_at);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // ---- reset state -------------------------------------------------
        idle_cycles(3);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_loaded, 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // ---- nominal, with start and in_valid coincident in IDLE ----------
        log_addr.delete();
        log_data.delete();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        @(negedge clk);
        start = 1'b0;
        check("start_ready", in_ready, 1);
        check("start_no_write", wr_en, 0);
        check("start_busy", busy, 1);
`ifdef WEIGHT_CHECKSUM_EN
        send_beats(DP, -1, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0078;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("cks_done_now", done, 1);
        check("cks_no_write", wr_en, 0);
        idle_cycles(2);
        check_writes("cks", DP);
        check("cks_err", err, 0);
        check("cks_words", words_loaded, DP);
        check("cks_ready", in_ready, 0);

        // ---- bad checksum ---------------------------------------------------
        start_load();
        send_beats(DP, -1, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0079;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle_cycles(2);
        check_writes("bad_cks", DP);
        check("bad_cks_err", err, 1);
        check("bad_cks_done", done, 0);

        // ---- checksum beat without last -------------------------------------
        start_load();
        send_beats(DP, -1, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0078;
        @(negedge clk);
        in_valid = 1'b0;
        idle_cycles(2);
        check("nolast_err", err, 1);
        check("nolast_done", done, 0);

        // ---- last on a data beat -----------------------------------------
        start_load();
        send_beats(5, 4, 1'b0);
        idle_cycles(2);
        check_writes("cks_short", 5);
        check("cks_short_err", err, 1);
`else
        send_beats(DP, DP - 1, 1'b0);
        check("nom_done_now", done, 1);
        check("nom_wr_now", wr_en, 1);
        idle_cycles(2);
        check_writes("nom", DP);
        check("nom_err", err, 0);
        check("nom_words", words_loaded, DP);
        check("nom_ready", in_ready, 0);
        check("nom_busy", busy, 0);

        // ---- gaps -----------------------------------------------------------
        start_load();
        send_beats(DP, DP - 1, 1'b1);
        idle_cycles(2);
        check_writes("gap", DP);
        check("gap_busy_low", busy_low, 0);
        check("gap_done", done, 1);

        // ---- short stream -------------------------------------------------
        start_load();
        check("short_clr_done", done, 0);
        send_beats(5, 4, 1'b0);
        idle_cycles(2);
        check_writes("short", 5);
        check("short_err", err, 1);
        check("short_done", done, 0);
        check("short_ready", in_ready, 0);
        check("short_words", words_loaded, 5);

        // ---- long stream ------------------------------------------------
        start_load();
        check("long_clr_err", err, 0);
        send_beats(DP, -1, 1'b0);
        check("long_err_now", err, 1);
        in_valid = 1'b1;
        in_data  = 16'h0099;
        repeat (3) begin
            @(negedge clk);
            if (in_ready !== 1'b0) ready_low++;
        end
        in_valid = 1'b0;
        idle_cycles(2);
        check_writes("long", DP);
        check("long_words", words_loaded, DP);
        check("long_done", done, 0);

        // ---- start during LOAD ignored ------------------------------------
        start_load();
        send_beats(3, -1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 3; i < DP; i++) begin
            if (in_ready !== 1'b1) ready_low++;
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            in_last  = (i == DP - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle_cycles(2);
        check_writes("restart", DP);
        check("restart_done", done, 1);
`endif

        // ---- reset mid-load -------------------------------------------------
        start_load();
        send_beats(5, -1, 1'b0);
        @(negedge clk);
        log_addr.delete();
        log_data.delete();
        in_valid = 1'b1;
        in_data  = 16'h0055;
        rst_n    = 1'b0;
        idle_cycles(3);
        check("mid_rst_writes", log_addr.size(), 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_words", words_loaded, 0);
        check("mid_rst_addr", wr_addr, 0);
        check("mid_rst_data", wr_data, 0);
        check("mid_rst_flags", {done, err}, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle_cycles(2);
        check("post_rst_idle", in_ready, 0);
        start_load();
`ifdef WEIGHT_CHECKSUM_EN
        send_beats(DP, -1, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h0078;
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
`else
        send_beats(DP, DP - 1, 1'b0);
`endif
        idle_cycles(2);
        check_writes("post_rst", DP);
        check("post_rst_done", done, 1);

        check("ready_during_load", ready_low, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_weight_loader
